// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Latency: n/a. Backpressure: n/a.
package inst_fetch_buf_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;
  // Decode sees an all-zero word (MIPS sll $0,$0,0) whenever nothing is buffered.
  localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Fetch-side and decode-side handshake bundle of the fetch buffer.
// Latency: n/a. Backpressure: if_ready towards fetch, id_ready from decode.
interface inst_fetch_buf_if
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int AW = $clog2(DEPTH);

  logic [INST_ADDR_W-1:0] if_pc;
  logic [INST_W-1:0]      if_inst;
  logic                   if_valid;
  logic                   if_ready;
  logic [INST_ADDR_W-1:0] id_pc;
  logic [INST_W-1:0]      id_inst;
  logic                   id_valid;
  logic                   id_ready;
  logic                   flush;
  logic [AW:0]            count;

  modport master (
    output if_pc, if_inst, if_valid, id_ready, flush,
    input  if_ready, id_pc, id_inst, id_valid, count
  );

  modport slave (
    input  if_pc, if_inst, if_valid, id_ready, flush,
    output if_ready, id_pc, id_inst, id_valid, count
  );

endinterface

// File: rtl/inst_fetch_buf_mem.sv
// DEPTH-entry storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on read port the cycle after. Backpressure: none.
module fetch_buf_mem
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_buf.sv
// In-order buffer of fetched {pc, inst} pairs between imem read port and decode; flush empties it.
// Latency: 1 cycle accept-to-visible. Backpressure: registered if_ready, frees one cycle after a pop at full.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_buf_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          if_ready_q, if_ready_d;
  logic          push, pop, not_empty;
  fetch_entry_t  wr_entry, rd_entry;

  assign not_empty = (count_q != '0);
  assign push      = bus.if_valid & if_ready_q & ~bus.flush;
  assign pop       = not_empty & bus.id_ready & ~bus.flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if_ready_d = if_ready_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      if_ready_d = 1'b1;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if_ready_d = (count_d < CNT_FULL);
    end
  end

  // if_ready resets low so fetch cannot push until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      if_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if_ready_q <= if_ready_d;
    end
  end

  assign wr_entry.pc   = bus.if_pc;
  assign wr_entry.inst = bus.if_inst;

  fetch_buf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign bus.id_valid = not_empty;
  assign bus.id_pc    = not_empty ? rd_entry.pc   : ZERO_WORD;
  assign bus.id_inst  = not_empty ? rd_entry.inst : NOP_INST;
  assign bus.if_ready = if_ready_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a queue scoreboard checked every cycle.
module tb_inst_fetch_buf
  import inst_fetch_buf_pkg::*;
;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_entry_t exp_q [$];
  logic         mrdy = 1'b0;
  logic         mpush, mpop;

  inst_fetch_buf_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: holds expected buffer contents and the expected registered if_ready.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
      chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      exp_q.delete();
      mrdy = 1'b1;
    end else begin
      chk("if_ready", 32'(bus.if_ready), 32'(mrdy));
      chk("id_valid", 32'(bus.id_valid), 32'(exp_q.size() != 0));
      chk("count", 32'(bus.count), 32'(exp_q.size()));
      if (exp_q.size() == 0) begin
        chk("empty_pc", bus.id_pc, 32'h0);
        chk("empty_inst", bus.id_inst, 32'h0);
      end else begin
        chk("head_pc", bus.id_pc, exp_q[0].pc);
        chk("head_inst", bus.id_inst, exp_q[0].inst);
      end
      mpush = bus.if_valid && mrdy && !bus.flush;
      mpop  = (exp_q.size() != 0) && bus.id_ready && !bus.flush;
      if (bus.flush) begin
        exp_q.delete();
        mrdy = 1'b1;
      end else begin
        if (mpop) void'(exp_q.pop_front());
        if (mpush) exp_q.push_back('{pc: bus.if_pc, inst: bus.if_inst});
        mrdy = (exp_q.size() < DEPTH);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] s_pc   [3];
  logic [31:0] s_inst [3];

  initial begin
    s_pc[0] = 32'h0; s_pc[1] = 32'h4; s_pc[2] = 32'h8;
    s_inst[0] = 32'h24010001; s_inst[1] = 32'h24020002; s_inst[2] = 32'h00221820;
    rst = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;
    bus.id_ready = 1'b0;
    bus.flush    = 1'b0;

    @(negedge clk);
    chk("reset_id_pc", bus.id_pc, 32'h0);
    chk("reset_id_inst", bus.id_inst, 32'h0);
    #1 rst = 1'b1;
    next();
    chk("if_ready_after_rst", 32'(bus.if_ready), 32'd1);

    // Streaming with decode always ready
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = s_pc[i];
      bus.if_inst  = s_inst[i];
      @(negedge clk);
      chk("stream_count", 32'(bus.count), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("stream_pc", bus.id_pc, s_pc[i-1]);
      next();
    end
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_pc", bus.id_pc, 32'h8);
    chk("stream_last_inst", bus.id_inst, 32'h00221820);
    next();
    @(negedge clk);
    chk("stream_drained", 32'(bus.id_valid), 32'd0);
    next();

    // Fill to full with decode stalled, fifth offer held
    bus.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = 32'(i * 4);
      bus.if_inst  = 32'h3c000000 | 32'(i);
      next();
    end
    bus.if_pc   = 32'h10;
    bus.if_inst = 32'h3c000004;
    @(negedge clk);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_if_ready", 32'(bus.if_ready), 32'd0);
    next();
    @(negedge clk);
    chk("full_hold_count", 32'(bus.count), 32'd4);
    next();
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_pc", bus.id_pc, 32'h0);
    chk("full_pop_if_ready", 32'(bus.if_ready), 32'd0);
    next();
    @(negedge clk);
    chk("after_pop_if_ready", 32'(bus.if_ready), 32'd1);
    chk("after_pop_count", 32'(bus.count), 32'd3);
    chk("after_pop_pc", bus.id_pc, 32'h4);
    next();
    bus.if_valid = 1'b0;
    for (int i = 0; i < 4; i++) next();
    @(negedge clk);
    chk("fill_drained", 32'(bus.id_valid), 32'd0);
    bus.id_ready = 1'b0;
    next();

    // Simultaneous push/pop at count=2 across pointer wrap
    bus.if_valid = 1'b1;
    bus.if_pc = 32'h100; bus.if_inst = 32'h11110000;
    next();
    bus.if_pc = 32'h104; bus.if_inst = 32'h11110001;
    next();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.if_pc   = 32'h108 + 32'(4 * i);
      bus.if_inst = 32'h11110002 + 32'(i);
      @(negedge clk);
      chk("pp_count", 32'(bus.count), 32'd2);
      next();
    end
    bus.if_valid = 1'b0;
    next();
    next();
    @(negedge clk);
    chk("pp_drained", 32'(bus.id_valid), 32'd0);
    bus.id_ready = 1'b0;
    next();

    // Flush at count=3 with a same-cycle offer
    for (int i = 0; i < 3; i++) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = 32'h200 + 32'(4 * i);
      bus.if_inst  = 32'h22220000 + 32'(i);
      next();
    end
    bus.if_pc = 32'h40; bus.if_inst = 32'hdeadbeef;
    bus.flush = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    next();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_id_valid", 32'(bus.id_valid), 32'd0);
    chk("flush_id_inst", bus.id_inst, 32'h0);
    chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
    next();
    next();

    // Flush while full with a pending offer, then flush while empty
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = 32'h500 + 32'(4 * i);
      bus.if_inst  = 32'h55550000 + 32'(i);
      next();
    end
    bus.flush = 1'b1;
    next();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_count", 32'(bus.count), 32'd0);
    chk("flush_full_if_ready", 32'(bus.if_ready), 32'd1);
    next();
    bus.flush = 1'b1;
    next();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_count", 32'(bus.count), 32'd0);
    chk("flush_empty_if_ready", 32'(bus.if_ready), 32'd1);
    next();

    // Asynchronous reset at count=2
    for (int i = 0; i < 2; i++) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = 32'h600 + 32'(4 * i);
      bus.if_inst  = 32'h66660000 + 32'(i);
      next();
    end
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("async_rst_if_ready", 32'(bus.if_ready), 32'd0);
    chk("async_rst_count", 32'(bus.count), 32'd0);
    chk("async_rst_id_pc", bus.id_pc, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    next();
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h700;
    bus.if_inst  = 32'h24030003;
    next();
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_pc", bus.id_pc, 32'h700);
    chk("post_rst_inst", bus.id_inst, 32'h24030003);
    next();

    // Empty with decode ready: no underflow
    bus.id_ready = 1'b1;
    next();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_id_valid", 32'(bus.id_valid), 32'd0);
      chk("idle_id_pc", bus.id_pc, 32'h0);
      chk("idle_id_inst", bus.id_inst, 32'h0);
      chk("idle_count", 32'(bus.count), 32'd0);
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
